// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list (circular FIFO of unmapped preg indices)
//
// Hands out up to two free physical registers per cycle to rename and takes back
// up to two per cycle from the ROB (stale pregs at retire, squashed p_rd on rollback).
// Optional build macro: FREELIST_DUPCHK_EN adds a free bitmap that drops double frees.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   alloc_req  [1:0]        per-lane allocate request (lane 1 only together with lane 0)
//   alloc_rdy  [1:0]        lane may allocate this cycle
//   alloc_preg [2*PRW-1:0]  preg offered to each lane, lane 0 in the low bits
//   rel_en     [1:0]        per-lane release valid
//   rel_preg   [2*PRW-1:0]  preg being released, lane 0 in the low bits
//   free_cnt   [PRW:0]      number of free pregs held
//   dup_err                 double free seen last cycle (always 0 without FREELIST_DUPCHK_EN)
module free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32,
    parameter int PRW      = $clog2(NUM_PREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alloc_req,
    output logic [1:0]       alloc_rdy,
    output logic [2*PRW-1:0] alloc_preg,
    input  logic [1:0]       rel_en,
    input  logic [2*PRW-1:0] rel_preg,
    output logic [PRW:0]     free_cnt,
    output logic             dup_err
);

    logic [PRW-1:0] fl [NUM_PREG];
    logic [PRW-1:0] head;
    logic [PRW-1:0] tail;
    logic [PRW:0]   cnt;

    logic [PRW-1:0] head_p1;
    logic [PRW-1:0] tail_p1;
    logic [PRW-1:0] p0;
    logic [PRW-1:0] p1;
    logic           g0;
    logic           g1;
    logic [1:0]     gcnt;
    logic           ok0;
    logic           ok1;
    logic           acc0;
    logic           acc1;
    logic [1:0]     acc_cnt;
    logic [PRW+1:0] room;

    assign head_p1 = head + PRW'(1);
    assign tail_p1 = tail + PRW'(1);
    assign p0      = rel_preg[PRW-1:0];
    assign p1      = rel_preg[2*PRW-1:PRW];

    assign alloc_rdy[0] = (cnt != '0);
    assign alloc_rdy[1] = (cnt >= (PRW+1)'(2));
    assign alloc_preg   = {fl[head_p1], fl[head]};
    assign free_cnt     = cnt;

    assign g0   = alloc_req[0] & alloc_rdy[0];
    assign g1   = g0 & alloc_req[1] & alloc_rdy[1];
    assign gcnt = {1'b0, g0} + {1'b0, g1};

`ifdef FREELIST_DUPCHK_EN
    logic [NUM_PREG-1:0] fb;
    logic                dup0;
    logic                dup1;

    // A preg whose free bit is already set is a double free. Lane 1 naming the
    // same preg as an accepted lane 0 is also a double free.
    assign dup0 = rel_en[0] & fb[p0];
    assign dup1 = rel_en[1] & (fb[p1] | (ok0 & (p0 == p1)));
    assign ok0  = rel_en[0] & ~dup0;
    assign ok1  = rel_en[1] & ~dup1;
`else
    assign ok0     = rel_en[0];
    assign ok1     = rel_en[1];
    assign dup_err = 1'b0;
`endif

    // Slots freed by this cycle's grants count as room: the grant reads the old
    // fl[head] combinationally while the write lands at the clock edge.
    assign room    = (PRW+2)'(NUM_PREG) - {1'b0, cnt} + (PRW+2)'(gcnt);
    assign acc0    = ok0 & (room >= (PRW+2)'(1));
    assign acc1    = ok1 & (room >= (acc0 ? (PRW+2)'(2) : (PRW+2)'(1)));
    assign acc_cnt = {1'b0, acc0} + {1'b0, acc1};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                fl[i] <= (i < NUM_PREG - NUM_AREG) ? PRW'(NUM_AREG + i) : '0;
            end
            head <= '0;
            tail <= PRW'(NUM_PREG - NUM_AREG);
            cnt  <= (PRW+1)'(NUM_PREG - NUM_AREG);
        end else begin
            head <= head + PRW'(gcnt);
            // Accepted releases are packed in lane order starting at tail.
            if (acc0) fl[tail] <= p0;
            if (acc1) fl[acc0 ? tail_p1 : tail] <= p1;
            tail <= tail + PRW'(acc_cnt);
            cnt  <= cnt + (PRW+1)'(acc_cnt) - (PRW+1)'(gcnt);
        end
    end

`ifdef FREELIST_DUPCHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                fb[i] <= (i >= NUM_AREG);
            end
            dup_err <= 1'b0;
        end else begin
            // A granted preg still has its bit set, so it can never be an accepted
            // release in the same cycle; the clear and set never collide.
            if (g0)   fb[fl[head]]    <= 1'b0;
            if (g1)   fb[fl[head_p1]] <= 1'b0;
            if (acc0) fb[p0]          <= 1'b1;
            if (acc1) fb[p1]          <= 1'b1;
            dup_err <= dup0 | dup1;
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list (64/32 configuration)
module tb_free_list;

    localparam int NP  = 64;
    localparam int NA  = 32;
    localparam int PRW = 6;
`ifdef FREELIST_DUPCHK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       alloc_req = '0;
    logic [1:0]       alloc_rdy;
    logic [2*PRW-1:0] alloc_preg;
    logic [1:0]       rel_en = '0;
    logic [2*PRW-1:0] rel_preg = '0;
    logic [PRW:0]     free_cnt;
    logic             dup_err;

    free_list #(.NUM_PREG(NP), .NUM_AREG(NA)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_rdy  (alloc_rdy),
        .alloc_preg (alloc_preg),
        .rel_en     (rel_en),
        .rel_preg   (rel_preg),
        .free_cnt   (free_cnt),
        .dup_err    (dup_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mq[$];      // reference free list, oldest first
    int exp_q[$];   // scoreboard of expected grants
    bit mfb[NP];    // reference free bitmap
    bit exp_dup;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        for (int i = 0; i < NP; i++) mfb[i] = (i >= NA);
        for (int i = NA; i < NP; i++) mq.push_back(i);
        exp_dup = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        alloc_req = 2'b11;
        rel_en    = 2'b00;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        alloc_req = 2'b00;
        model_reset();
        #1;
        check_val("rst_free_cnt", free_cnt, 32);
        check_val("rst_alloc_rdy", alloc_rdy, 2'b11);
        check_val("rst_alloc_preg", alloc_preg, {6'd33, 6'd32});
        check_val("rst_dup_err", dup_err, 0);
    endtask

    // One cycle: drive, check combinational grant side, advance, check registered side.
    task automatic step(input logic [1:0] req, input logic [1:0] ren, input int p1, input int p0);
        int  c_old;
        int  e;
        int  room;
        bit  g0, g1, ok0, ok1, d0, d1, a0, a1;
        logic [5:0] q0, q1;
        q0 = p0[5:0];
        q1 = p1[5:0];
        alloc_req = req;
        rel_en    = ren;
        rel_preg  = {q1, q0};
        #1;
        c_old = mq.size();
        check_val("alloc_rdy", alloc_rdy, {30'd0, c_old >= 2, c_old >= 1});
        g0 = req[0] && (c_old >= 1);
        g1 = g0 && req[1] && (c_old >= 2);
        if (g0) exp_q.push_back(mq[0]);
        if (g1) exp_q.push_back(mq[1]);
        if (g0) begin
            e = exp_q.pop_front();
            check_val("grant0", alloc_preg[5:0], e);
            void'(mq.pop_front());
        end
        if (g1) begin
            e = exp_q.pop_front();
            check_val("grant1", alloc_preg[11:6], e);
            void'(mq.pop_front());
        end
        d0  = ren[0] && DUP && mfb[q0];
        ok0 = ren[0] && !d0;
        d1  = ren[1] && DUP && (mfb[q1] || (ok0 && q0 == q1));
        ok1 = ren[1] && !d1;
        room = NP - c_old + int'(g0) + int'(g1);
        a0 = ok0 && room >= 1;
        a1 = ok1 && room >= (a0 ? 2 : 1);
        if (DUP) begin
            if (g0) mfb[alloc_preg[5:0]] = 1'b0;
            if (g1) mfb[alloc_preg[11:6]] = 1'b0;
        end
        if (a0) begin mq.push_back(q0); mfb[q0] = 1'b1; end
        if (a1) begin mq.push_back(q1); mfb[q1] = 1'b1; end
        exp_dup = d0 || d1;
        @(posedge clk);
        #1;
        alloc_req = 2'b00;
        rel_en    = 2'b00;
        check_val("free_cnt", free_cnt, mq.size());
        check_val("dup_err", dup_err, exp_dup);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40 && mq.size() > 0; i++) step(2'b11, 2'b00, 0, 0);
        check_val("drained", free_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset
        do_reset();

        // 2: drain 32..63 in order, then a request with nothing free
        for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 0, 0);
        check_val("drain_cnt", free_cnt, 0);
        check_val("drain_rdy", alloc_rdy, 2'b00);
        step(2'b11, 2'b00, 0, 0);
        check_val("empty_cnt", free_cnt, 0);

        // 3: refill from empty, no bypass
        alloc_req = 2'b11;
        rel_en    = 2'b11;
        rel_preg  = {6'd7, 6'd5};
        #1;
        check_val("nobypass_rdy", alloc_rdy, 2'b00);
        step(2'b11, 2'b11, 7, 5);
        check_val("refill_rdy", alloc_rdy, 2'b11);
        check_val("refill_preg", alloc_preg, {6'd7, 6'd5});
        check_val("refill_cnt", free_cnt, 2);

        // 4: simultaneous alloc+release at cnt=2, then lane-1-only release
        step(2'b11, 2'b11, 9, 8);
        check_val("simul_cnt", free_cnt, 2);
        check_val("simul_preg", alloc_preg, {6'd9, 6'd8});
        step(2'b00, 2'b10, 12, 0);
        step(2'b10, 2'b00, 0, 0);   // lane 1 alone is not granted
        step(2'b11, 2'b00, 0, 0);
        check_val("lane1_tail", alloc_preg[5:0], 12);
        step(2'b01, 2'b00, 0, 0);

        // 5: wrap passes with rotating release order
        drain_all();
        for (int pass = 0; pass < 3; pass++) begin
            for (int j = 0; j < 32; j++) begin
                step(2'b00, 2'b11, (2*j + 1 + 17*pass) % NP, (2*j + 17*pass) % NP);
                check_val("cnt_le_64", free_cnt <= 64, 1);
            end
            if (pass == 0) begin
                step(2'b00, 2'b01, 0, 3);   // full: release must be dropped
                check_val("full_cnt", free_cnt, 64);
            end
            drain_all();
        end

`ifdef FREELIST_DUPCHK_EN
        // 6: double-free detection and mid-drain reset
        do_reset();
        step(2'b00, 2'b01, 0, 40);
        check_val("dup40_err", dup_err, 1);
        check_val("dup40_cnt", free_cnt, 32);
        step(2'b00, 2'b00, 0, 0);
        check_val("dup40_clear", dup_err, 0);
        for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 0, 0);
        step(2'b00, 2'b11, 50, 50);
        check_val("dup50_cnt", free_cnt, 13);
        check_val("dup50_err", dup_err, 1);
        step(2'b11, 2'b00, 0, 0);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
